// File: rtl/keypad_encoder_if.sv
// Key matrix pins plus the encoded key interface towards the calculator.
// master = encoder side (drives rows and key strobe), slave = matrix/consumer side.
interface keypad_encoder_if;
  logic [3:0] row;
  logic [7:0] col;
  logic       new_key;
  logic [4:0] keycode;

  modport master (
    output row,
    output new_key,
    output keycode,
    input  col
  );

  modport slave (
    input  row,
    input  new_key,
    input  keycode,
    output col
  );
endinterface

// File: rtl/keypad_encoder.sv
// Scans a 4x8 active-low key matrix, debounces presses/releases, emits keycode + one-cycle new_key.
// Latency: 2-cycle column sync, then DEBOUNCE_CYCLES after detection; no backpressure, new_key is a strobe.
module keypad_encoder #(
  parameter int SCAN_DIV        = 500,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  keypad_encoder_if.master  kp
);

  localparam int CNT_TOP = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [2:0]    key_col, key_col_nxt;
  logic          new_key_q, new_key_nxt;
  logic [4:0]    keycode_q, keycode_nxt;
  logic [7:0]    col_m, col_s;

  logic          any_low;
  logic [2:0]    low_col;
  logic          key_up;

  // Descending loop so the lowest-index low column is the last assignment.
  always_comb begin
    any_low = ~&col_s;
    low_col = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!col_s[i]) low_col = 3'(i);
    end
  end

  assign key_up  = col_s[key_col];
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    row_idx_nxt = row_idx;
    key_col_nxt = key_col;
    new_key_nxt = 1'b0;
    keycode_nxt = keycode_q;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nxt = '0;
          if (any_low) begin
            key_col_nxt = low_col;
            state_nxt   = DEBOUNCE;
          end else begin
            row_idx_nxt = row_idx + 2'd1;
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      DEBOUNCE: begin
        if (key_up) begin
          cnt_nxt   = '0;
          state_nxt = SCAN;
        end else if (cnt == DEB_LAST) begin
          cnt_nxt     = '0;
          new_key_nxt = 1'b1;
          keycode_nxt = {row_idx, key_col};
          state_nxt   = HELD;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        cnt_nxt = '0;
        if (key_up) state_nxt = RELEASE;
      end
      RELEASE: begin
        // Any bounce back to pressed restarts the release qualification.
        if (!key_up) begin
          cnt_nxt   = '0;
          state_nxt = HELD;
        end else if (cnt == DEB_LAST) begin
          cnt_nxt     = '0;
          row_idx_nxt = row_idx + 2'd1;
          state_nxt   = SCAN;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = SCAN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      cnt       <= '0;
      row_idx   <= 2'd0;
      key_col   <= 3'd0;
      new_key_q <= 1'b0;
      keycode_q <= 5'd0;
      col_m     <= 8'hFF;
      col_s     <= 8'hFF;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      row_idx   <= row_idx_nxt;
      key_col   <= key_col_nxt;
      new_key_q <= new_key_nxt;
      keycode_q <= keycode_nxt;
      col_m     <= kp.col;
      col_s     <= col_m;
    end
  end

  assign kp.row     = ~(4'b0001 << row_idx);
  assign kp.new_key = new_key_q;
  assign kp.keycode = keycode_q;

endmodule
